// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO.
// Used by both the write-side and read-side controllers.
package fifo_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int PTR_W      = ADDR_W_DEF + 1;
    localparam int PTR_MAX_W  = 13;

    // Zero-extended inputs convert correctly at any width up to PTR_MAX_W.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(
        input logic [PTR_MAX_W-1:0] v
    );
        return v ^ (v >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(
        input logic [PTR_MAX_W-1:0] v
    );
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX_W; i++)
            b[i] = ^(v >> i);
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter.
// Bit i is the XOR of all Gray bits at and above i.
module fifo_wr_ctrl_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Prefix XOR from the MSB down
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++)
            bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the dual-clock FIFO.
// Drives the RAM write port and exports the Gray write pointer.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 2 ** ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   waddr_gray,
    input  logic [ADDR_W:0]   rq2_rgray,
    output logic              wfull,
    output logic              almost_full,
    output logic [ADDR_W:0]   wlevel,
    input  logic              ovf_clr,
    output logic              overflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] lvl_next;
    logic [PW-1:0] full_cmp;
    logic          acc;

    fifo_wr_ctrl_gray2bin #(
        .W(PW)
    ) u_rg2b (
        .gray(rq2_rgray),
        .bin (rbin)
    );

    // Handshake, next pointer and next flag values
    always_comb begin
        acc        = wr_valid && !wfull;
        wr_ready   = !wfull;
        wr_en      = acc && !rst;
        waddr      = wbin[ADDR_W-1:0];
        wbin_next  = wbin + PW'(acc);
        wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
        lvl_next   = wbin_next - rbin;
        full_cmp   = {~rq2_rgray[ADDR_W:ADDR_W-1],
                      rq2_rgray[ADDR_W-2:0]};
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin        <= '0;
            waddr_gray  <= '0;
            wfull       <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            waddr_gray  <= wgray_next;
            wfull       <= (wgray_next == full_cmp);
            almost_full <= (lvl_next >= AF_T);
            wlevel      <= lvl_next;
            if (wr_valid && wfull)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at ADDR_W=2, AF_THRESH=3.
// Expected values are hand-derived or from a pointer scoreboard.
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_en;
    logic [1:0] waddr;
    logic [2:0] waddr_gray;
    logic [2:0] rq2_rgray;
    logic       wfull;
    logic       almost_full;
    logic [2:0] wlevel;
    logic       ovf_clr;
    logic       overflow;

    int checks;
    int errors;

    fifo_wr_ctrl #(
        .ADDR_W   (2),
        .AF_THRESH(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_en      (wr_en),
        .waddr      (waddr),
        .waddr_gray (waddr_gray),
        .rq2_rgray  (rq2_rgray),
        .wfull      (wfull),
        .almost_full(almost_full),
        .wlevel     (wlevel),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs may change right after return
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk_regs(input string tag, input logic [2:0] gr,
                            input logic f, input logic af,
                            input logic [2:0] lv, input logic ov);
        chk({tag, ".gray"}, 32'(waddr_gray), 32'(gr));
        chk({tag, ".full"}, 32'(wfull), 32'(f));
        chk({tag, ".af"}, 32'(almost_full), 32'(af));
        chk({tag, ".lvl"}, 32'(wlevel), 32'(lv));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
    endtask

    logic [2:0] exp_gray [4];
    logic [2:0] wb_m, last_w, prev_w;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        wr_valid = 1'b1;
        ovf_clr  = 1'b0;
        rq2_rgray = 3'b000;
        exp_gray[0] = 3'b001;
        exp_gray[1] = 3'b011;
        exp_gray[2] = 3'b010;
        exp_gray[3] = 3'b110;

        // 1. reset with valid held
        tick();
        #1 chk("rst.wr_en0", 32'(wr_en), 32'd0);
        tick();
        #1 chk("rst.wr_en1", 32'(wr_en), 32'd0);
        chk_regs("rst", 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("rst.ready", 32'(wr_ready), 32'd1);

        // 2. fill
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill.wr_en", 32'(wr_en), 32'd1);
            chk("fill.waddr", 32'(waddr), 32'(i));
            tick();
            chk_regs("fill", exp_gray[i], (i == 3), (i >= 2),
                     3'(i + 1), 1'b0);
        end

        // 3. overflow
        for (int i = 0; i < 2; i++) begin
            #1 chk("ovf.wr_en", 32'(wr_en), 32'd0);
            chk("ovf.ready", 32'(wr_ready), 32'd0);
            tick();
            chk_regs("ovf", 3'b110, 1'b1, 1'b1, 3'd4, 1'b1);
        end
        wr_valid = 1'b0;
        tick();
        chk("ovf.hold", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        chk("ovf.clr", 32'(overflow), 32'd0);
        wr_valid = 1'b1;
        tick();
        chk("ovf.setwins", 32'(overflow), 32'd1);
        chk("ovf.gray", 32'(waddr_gray), 32'b110);
        wr_valid = 1'b0;
        tick();
        chk("ovf.clr2", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;

        // 4. release
        rq2_rgray = 3'b001;
        tick();
        chk_regs("rel", 3'b110, 1'b0, 1'b1, 3'd3, 1'b0);
        wr_valid = 1'b1;
        #1 chk("rel.waddr", 32'(waddr), 32'd0);
        chk("rel.wr_en", 32'(wr_en), 32'd1);
        tick();
        chk_regs("rel2", 3'b111, 1'b1, 1'b1, 3'd4, 1'b0);

        // 5. wrap with lagging read pointer
        wr_valid = 1'b0;
        rst = 1'b1;
        rq2_rgray = 3'b000;
        tick();
        rst = 1'b0;
        wb_m = 3'd0;
        last_w = 3'd0;
        prev_w = 3'd0;
        for (int k = 0; k < 40; k++) begin
            wr_valid = (k % 2 == 0);
            rq2_rgray = g(prev_w);
            #1;
            if (wr_valid) begin
                chk("wrap.waddr", 32'(waddr), 32'(wb_m[1:0]));
                chk("wrap.wr_en", 32'(wr_en), 32'd1);
            end
            tick();
            if (wr_valid) wb_m = wb_m + 3'd1;
            chk_regs("wrap", g(wb_m), 1'b0,
                     ((wb_m - prev_w) >= 3'd3),
                     wb_m - prev_w, 1'b0);
            chk("wrap.lvlmax", 32'(wlevel <= 3'd3), 32'd1);
            prev_w = last_w;
            last_w = wb_m;
        end
        chk("wrap.final", 32'(waddr_gray), 32'(g(3'd4)));

        // 6. mid-operation reset
        wr_valid = 1'b0;
        rst = 1'b1;
        rq2_rgray = 3'b000;
        tick();
        rst = 1'b0;
        wr_valid = 1'b1;
        tick();
        tick();
        tick();
        chk_regs("mid", 3'b010, 1'b0, 1'b1, 3'd3, 1'b0);
        rst = 1'b1;
        tick();
        chk_regs("midrst", 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        #1 chk("midrst.waddr", 32'(waddr), 32'd0);
        chk("midrst.wr_en", 32'(wr_en), 32'd1);
        tick();
        chk_regs("midwr", 3'b001, 1'b0, 1'b0, 3'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
